// File: rtl/mc_core_pkg.sv
// Shared types and encodings for the mc_core multicycle RV32I-subset core:
// FSM states, opcode/funct constants, ALU ops and immediate formats.
package mc_core_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_t;

  function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic sub);
    case (f3)
      F3_SLT:  return ALU_SLT;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return sub ? ALU_SUB : ALU_ADD;
    endcase
  endfunction

  function automatic logic signed [31:0] imm_gen(input logic [31:0] ir, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/mc_core_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port; x0 reads as zero and ignores writes.
module mc_core_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mc_core.sv
// Multicycle core for lw/sw/add/sub/and/or/slt/addi/andi/ori/slti/beq/jal.
// Define MC_CORE_PERF_EN to build the cycle and retired-instruction counters.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret_cnt
);

  localparam int AW = $clog2(NREGS);

  state_t state, next_state;
  logic signed [XLEN-1:0] pc, old_pc, a_reg, b_reg, alu_out, mdr, imm;
  logic [31:0] ir;
  logic [XLEN-1:0] rs1_data, rs2_data, rf_wdata;
  logic rf_we;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  state_t   dec_next;
  imm_fmt_t imm_fmt;
  logic     use_rd, use_rs1, use_rs2, legal, idx_bad;

  function automatic logic signed [XLEN-1:0] alu(input logic signed [XLEN-1:0] a,
                                                 input logic signed [XLEN-1:0] b,
                                                 input alu_op_t op);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (a < b) ? XLEN'(1) : '0;
      default: return a + b;
    endcase
  endfunction

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  always_comb begin
    dec_next = S_HALT;
    imm_fmt  = IMM_I;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    legal    = 1'b0;
    case (opcode)
      OP_LOAD: begin
        legal = (f3 == F3_LW); dec_next = S_MEMADR; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE: begin
        legal = (f3 == F3_SW); dec_next = S_MEMADR; imm_fmt = IMM_S;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_REG: begin
        legal = ((f7 == F7_BASE) && (f3 inside {F3_ADD, F3_SLT, F3_OR, F3_AND})) ||
                ((f7 == F7_SUB) && (f3 == F3_ADD));
        dec_next = S_EXECR; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_IMM: begin
        legal = (f3 inside {F3_ADD, F3_SLT, F3_OR, F3_AND});
        dec_next = S_EXECI; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        legal = (f3 == F3_BEQ); dec_next = S_BEQ; imm_fmt = IMM_B;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1; dec_next = S_JAL; imm_fmt = IMM_J; use_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // Only the register fields an instruction actually uses are range-checked.
  assign idx_bad = (NREGS == 16) && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
  assign imm     = XLEN'(imm_gen(ir, imm_fmt));

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = (legal && !idx_bad) ? dec_next : S_HALT;
      S_MEMADR: next_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ: next_state = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
      default:  next_state = S_HALT;
    endcase
  end

  // PC and IR carry architectural reset values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata[31:0];
          pc <= pc + XLEN'(4);
        end
        S_BEQ:   if (a_reg == b_reg) pc <= alu_out;
        S_JAL:   pc <= alu_out;
        default: ;
      endcase
    end
  end

  // Scratch datapath registers; always written before being consumed.
  always_ff @(posedge clk) begin
    case (state)
      S_FETCH:  if (mem_ready) old_pc <= pc;
      S_DECODE: begin
        a_reg   <= rs1_data;
        b_reg   <= rs2_data;
        alu_out <= old_pc + imm;
      end
      S_MEMADR: alu_out <= a_reg + imm;
      S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
      S_EXECR:  alu_out <= alu(a_reg, b_reg, alu_op_of(f3, f7[5]));
      S_EXECI:  alu_out <= alu(a_reg, imm, alu_op_of(f3, 1'b0));
      S_JAL:    alu_out <= pc;
      default:  ;
    endcase
  end

  assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we    = mem_req && (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : alu_out;
  assign mem_wdata = b_reg;
  assign halted    = (state == S_HALT);

  assign rf_we    = !reset && ((state == S_MEMWB) || (state == S_ALUWB));
  assign rf_wdata = (state == S_MEMWB) ? mdr : alu_out;

  mc_core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1[AW-1:0]),
    .raddr2 (rs2[AW-1:0]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (rf_we),
    .waddr  (rd[AW-1:0]),
    .wdata  (rf_wdata)
  );

`ifdef MC_CORE_PERF_EN
  logic [31:0] cyc_q, ret_q;
  logic        retire;
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWR) && mem_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire) ret_q <= ret_q + 32'd1;
    end
  end
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: instruction memory with configurable wait
// states, store overlay, and a second NREGS=16 core for index legality.
module tb_mc_core;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            mem_req, mem_we, mem_ready, halted;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0]     cycle_cnt, instret_cnt;

  logic            mem_req16, mem_we16, halted16;
  logic [XLEN-1:0] mem_addr16, mem_wdata16;
  logic [XLEN-1:0] rdata16 = '0;
  logic            ready16 = 1'b1;
  logic [31:0]     cycle16, instret16;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic [63:0] dvalid;
  int unsigned delay = 0;
  int unsigned wcnt;
  logic [5:0]  idx;

  int checks = 0;
  int errors = 0;

  mc_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  mc_core #(.NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .mem_req(mem_req16), .mem_we(mem_we16),
    .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_rdata(rdata16),
    .mem_ready(ready16), .halted(halted16), .cycle_cnt(cycle16),
    .instret_cnt(instret16)
  );

  assign idx       = mem_addr[7:2];
  assign mem_ready = mem_req && (wcnt >= delay);
  assign mem_rdata = dvalid[idx] ? dmem[idx] : imem[idx];

  always @(posedge clk) begin
    if (reset) dvalid <= '0;
    else if (mem_req && mem_we && mem_ready) begin
      dmem[idx]   <= mem_wdata;
      dvalid[idx] <= 1'b1;
    end
    if (reset || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  function automatic logic [31:0] enc_i(int rd, int rs1, int imm, logic [2:0] f3, logic [6:0] op);
    logic [31:0] v, d, s;
    v = imm; d = rd; s = rs1;
    return {v[11:0], s[4:0], f3, d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2, logic [2:0] f3, logic [6:0] f7);
    logic [31:0] d, s, t;
    d = rd; s = rs1; t = rs2;
    return {f7, t[4:0], s[4:0], f3, d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(int rs2, int rs1, int imm);
    logic [31:0] v, s, t;
    v = imm; s = rs1; t = rs2;
    return {v[11:5], t[4:0], s[4:0], 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_beq(int rs1, int rs2, int imm);
    logic [31:0] v, s, t;
    v = imm; s = rs1; t = rs2;
    return {v[12], v[10:5], t[4:0], s[4:0], 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(int rd, int imm);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(rd, rs1, imm, 3'b000, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return enc_i(rd, rs1, imm, 3'b010, 7'b0000011);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    check("req_during_reset", mem_req, 0);
    reset = 1'b0;
    #1;
    check("post_reset_req", mem_req, 1);
    check("post_reset_addr", mem_addr, 0);
    check("post_reset_halted", halted, 0);
    check("post_reset_cycle", cycle_cnt, 0);
    check("post_reset_instret", instret_cnt, 0);
  endtask

  int unsigned exp_cyc, exp_ret;
  bit found;

  initial begin
    // Three ALU instructions, zero wait states.
    clear_imem();
    imem[0] = addi(1, 0, 5);
    imem[1] = addi(2, 0, 7);
    imem[2] = enc_r(3, 1, 2, 3'b000, 7'b0000000);
    imem[3] = enc_jal(0, 0);
    delay = 0;
    do_reset();
    tick(12);
    check("x1", dut.u_regfile.regs[1], 5);
    check("x2", dut.u_regfile.regs[2], 7);
    check("x3_add", dut.u_regfile.regs[3], 12);
    check("fetch_after_3", mem_addr, 32'h0C);
`ifdef MC_CORE_PERF_EN
    exp_cyc = 12; exp_ret = 3;
`else
    exp_cyc = 0; exp_ret = 0;
`endif
    check("cycle_cnt_12", cycle_cnt, exp_cyc);
    check("instret_3", instret_cnt, exp_ret);

    // Store then load through address 8 with three wait states per access.
    clear_imem();
    imem[0] = addi(3, 0, 12);
    imem[1] = enc_jal(0, 8);
    imem[3] = enc_sw(3, 0, 8);
    imem[4] = lw(4, 0, 8);
    imem[5] = enc_jal(0, 0);
    delay = 3;
    do_reset();
    check("x3_cleared", dut.u_regfile.regs[3], 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_req && mem_we) found = 1'b1;
      else tick(1);
    end
    check("sw_seen", found, 1);
    for (int i = 0; i < 4; i++) begin
      check("sw_req", mem_req, 1);
      check("sw_we", mem_we, 1);
      check("sw_addr", mem_addr, 8);
      check("sw_wdata", mem_wdata, 12);
      check("sw_ready", mem_ready, (i == 3));
      tick(1);
    end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_req && !mem_we && mem_addr == 8) found = 1'b1;
      else tick(1);
    end
    check("lw_seen", found, 1);
    for (int i = 0; i < 4; i++) begin
      check("lw_req", mem_req, 1);
      check("lw_addr", mem_addr, 8);
      tick(1);
    end
    tick(1);
    check("x4_load", dut.u_regfile.regs[4], 12);

    // Taken branch back to 0x08.
    clear_imem();
    imem[0] = addi(1, 0, 3);
    imem[1] = addi(2, 0, 4);
    imem[2] = enc_jal(0, 8);
    imem[4] = enc_beq(1, 1, -8);
    delay = 0;
    do_reset();
    check("x4_cleared", dut.u_regfile.regs[4], 0);
    tick(12);
    check("beq_at_10", mem_addr, 32'h10);
    tick(3);
    check("beq_taken", mem_addr, 32'h08);
`ifdef MC_CORE_PERF_EN
    exp_ret = 4;
`else
    exp_ret = 0;
`endif
    check("instret_beq", instret_cnt, exp_ret);

    // Not-taken branch falls through to 0x14.
    imem[4] = enc_beq(1, 2, -8);
    do_reset();
    tick(12);
    check("beq2_at_10", mem_addr, 32'h10);
    tick(3);
    check("beq_not_taken", mem_addr, 32'h14);

    // Jumps that wrap around the top of the address space.
    clear_imem();
    imem[0]  = addi(1, 0, 9);
    imem[1]  = enc_jal(0, -8);
    imem[63] = enc_jal(1, 16);
    do_reset();
    tick(8);
    check("jal_neg_target", mem_addr, 32'hFFFFFFFC);
    check("x1_before_jal", dut.u_regfile.regs[1], 9);
    tick(4);
    check("jal_link_wrap", dut.u_regfile.regs[1], 0);
    check("jal_target_wrap", mem_addr, 32'h0C);

    // Illegal opcode, and rd=x20 on the 16-register core.
    clear_imem();
    imem[0] = 32'h0000007F;
    rdata16 = addi(20, 0, 1);
    do_reset();
    tick(1);
    check("halt_not_yet", halted, 0);
    tick(1);
    check("halted_opcode", halted, 1);
    check("halt_req", mem_req, 0);
    check("halted16_rd20", halted16, 1);
    check("halt16_req", mem_req16, 0);
    check("halt16_we", mem_we16, 0);
    tick(5);
    check("halt_sticky", halted, 1);
    check("halt_req_sticky", mem_req, 0);
    check("halt_x0", dut.u_regfile.regs[1], 0);

    // Illegal funct (sub-encoding with and), legal x5 on the 16-register core.
    imem[0] = enc_r(3, 1, 2, 3'b111, 7'b0100000);
    rdata16 = addi(5, 0, 1);
    do_reset();
    check("fetch16_addr", mem_addr16, 0);
    tick(2);
    check("halted_funct", halted, 1);
    check("not_halted16_x5", halted16, 0);
`ifdef MC_CORE_PERF_EN
    exp_cyc = 2;
`else
    exp_cyc = 0;
`endif
    check("cycle16", cycle16, exp_cyc);

    // Reset during a stalled load read.
    clear_imem();
    imem[0] = lw(4, 0, 0);
    delay = 0;
    do_reset();
    tick(2);
    delay = 100;
    tick(1);
    check("memrd_req", mem_req, 1);
    check("memrd_we", mem_we, 0);
    check("memrd_addr", mem_addr, 0);
    tick(2);
    check("memrd_hold", mem_req, 1);
    reset = 1'b1;
    #1;
    check("memrd_reset_req", mem_req, 0);
    tick(1);
    reset = 1'b0;
    delay = 0;
    #1;
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 0);
    check("restart_x4", dut.u_regfile.regs[4], 0);
    tick(5);
    check("reload_x4", dut.u_regfile.regs[4], lw(4, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
